// File: rtl/decode_unstuff.sv
// decode_unstuff: JPEG entropy-stream byte unstuffer for the decode path.
// Removes stuffed 0x00 bytes that follow a data 0xFF and repacks the surviving
// bytes into dense 32-bit words. Only a 32-bit word width (4 bytes) is supported.
//
// Optional feature macro: DECODE_UNSTUFF_MARKER_EN
//   defined   : 0xFF + 0xFF is a fill byte (one 0xFF dropped), 0xFF + other
//               non-zero byte is a marker (both dropped, code reported).
//   undefined : only 0xFF00 -> 0xFF applies. A data 0xFF is forwarded at once
//               and pend_ff only remembers to drop a directly following 0x00,
//               so a word can never produce more than 4 bytes of stage data.

module decode_unstuff #(
    parameter int PIC_PIX_IN_WIDTH = 32
) (
    input  logic                        clk_x8_i,
    input  logic                        rst_n_i,
    input  logic [PIC_PIX_IN_WIDTH-1:0] pic_data_in_i,
    input  logic                        pic_data_in_valid_i,
    input  logic                        flush_i,
    output logic [PIC_PIX_IN_WIDTH-1:0] pic_data_out_o,
    output logic                        pic_data_out_valid_o,
    output logic [2:0]                  pic_data_out_bytes_o,
    output logic                        marker_valid_o,
    output logic [7:0]                  marker_code_o,
    output logic                        marker_lost_o,
    output logic                        flush_done_o
);

    // Carried scan state and stage register
    logic        pend_ff_q, pend_ff_d;
    logic [31:0] stage_data_q, stage_data_d;
    logic [2:0]  stage_cnt_q, stage_cnt_d;
    logic        stage_valid_q, stage_valid_d;

    // Residual byte buffer and flush request
    logic [23:0] acc_data_q, acc_data_d;
    logic [1:0]  acc_cnt_q, acc_cnt_d;
    logic        flush_pend_q, flush_pend_d;

    // Registered outputs
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic        flush_done_q, flush_done_d;

    // Scan results for the current input word
    logic        scan_pend;
    logic [31:0] kept_data;
    logic [2:0]  kept_cnt;
    logic [7:0]  cur_byte;

    // Assembly helpers
    logic [55:0] merged;
    logic [2:0]  total;
    logic        flush_exec;

`ifdef DECODE_UNSTUFF_MARKER_EN
    logic [1:0]  mk_cnt;
    logic [7:0]  mk_code;
    logic        stage_mk_q, stage_mk_d;
    logic [7:0]  stage_code_q, stage_code_d;
    logic        stage_lost_q, stage_lost_d;
    logic        marker_valid_q, marker_valid_d;
    logic [7:0]  marker_code_q, marker_code_d;
    logic        marker_lost_q, marker_lost_d;
`endif

    // The flush only fires once the stage register holds no unassembled word
    assign flush_exec = flush_pend_q && !stage_valid_q;

    // Scan the four input bytes in stream order and compact the kept ones low-first
    always_comb begin
        scan_pend = pend_ff_q;
        kept_data = '0;
        kept_cnt  = '0;
        cur_byte  = '0;
`ifdef DECODE_UNSTUFF_MARKER_EN
        mk_cnt    = '0;
        mk_code   = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            cur_byte = pic_data_in_i[i*8 +: 8];
`ifdef DECODE_UNSTUFF_MARKER_EN
            if (!scan_pend) begin
                if (cur_byte == 8'hFF) begin
                    scan_pend = 1'b1;
                end else begin
                    kept_data[{kept_cnt[1:0], 3'b000} +: 8] = cur_byte;
                    kept_cnt = kept_cnt + 3'd1;
                end
            end else if (cur_byte == 8'h00) begin
                kept_data[{kept_cnt[1:0], 3'b000} +: 8] = 8'hFF;
                kept_cnt  = kept_cnt + 3'd1;
                scan_pend = 1'b0;
            end else if (cur_byte != 8'hFF) begin
                mk_cnt    = mk_cnt + 2'd1;
                mk_code   = cur_byte;
                scan_pend = 1'b0;
            end
`else
            if (scan_pend && (cur_byte == 8'h00)) begin
                scan_pend = 1'b0;
            end else begin
                kept_data[{kept_cnt[1:0], 3'b000} +: 8] = cur_byte;
                kept_cnt  = kept_cnt + 3'd1;
                scan_pend = (cur_byte == 8'hFF);
            end
`endif
        end
    end

    // Load the stage register and advance the carried 0xFF flag
    always_comb begin
        stage_valid_d = pic_data_in_valid_i;
        stage_data_d  = pic_data_in_valid_i ? kept_data : '0;
        stage_cnt_d   = pic_data_in_valid_i ? kept_cnt : '0;
        pend_ff_d     = pend_ff_q;
        if (flush_exec) begin
            pend_ff_d = 1'b0;
        end else if (pic_data_in_valid_i) begin
            pend_ff_d = scan_pend;
        end
    end

    // Merge stage bytes behind the residual bytes; emit a full word or run the flush
    always_comb begin
        merged       = {32'h0, acc_data_q} | ({24'h0, stage_data_q} << {acc_cnt_q, 3'b000});
        total        = {1'b0, acc_cnt_q} + stage_cnt_q;
        acc_data_d   = acc_data_q;
        acc_cnt_d    = acc_cnt_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        out_valid_d  = 1'b0;
        flush_done_d = 1'b0;
        flush_pend_d = flush_pend_q | flush_i;
        if (stage_valid_q) begin
            if (total[2]) begin
                out_data_d  = merged[31:0];
                out_bytes_d = 3'd4;
                out_valid_d = 1'b1;
                acc_data_d  = merged[55:32];
            end else begin
                acc_data_d  = merged[23:0];
            end
            acc_cnt_d = total[1:0];
        end else if (flush_exec) begin
            if (acc_cnt_q != 2'd0) begin
                out_data_d  = {8'h00, acc_data_q};
                out_bytes_d = {1'b0, acc_cnt_q};
                out_valid_d = 1'b1;
            end
            acc_data_d   = '0;
            acc_cnt_d    = '0;
            flush_done_d = 1'b1;
            flush_pend_d = flush_i;
        end
    end

    // State and output registers
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_ff_q     <= 1'b0;
            stage_data_q  <= '0;
            stage_cnt_q   <= '0;
            stage_valid_q <= 1'b0;
            acc_data_q    <= '0;
            acc_cnt_q     <= '0;
            flush_pend_q  <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_bytes_q   <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            pend_ff_q     <= pend_ff_d;
            stage_data_q  <= stage_data_d;
            stage_cnt_q   <= stage_cnt_d;
            stage_valid_q <= stage_valid_d;
            acc_data_q    <= acc_data_d;
            acc_cnt_q     <= acc_cnt_d;
            flush_pend_q  <= flush_pend_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_bytes_q   <= out_bytes_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign pic_data_out_o       = out_data_q;
    assign pic_data_out_valid_o = out_valid_q;
    assign pic_data_out_bytes_o = out_bytes_q;
    assign flush_done_o         = flush_done_q;

`ifdef DECODE_UNSTUFF_MARKER_EN
    // Stage marker info with the word, report it when that word is assembled
    always_comb begin
        stage_mk_d     = pic_data_in_valid_i && (mk_cnt != 2'd0);
        stage_code_d   = pic_data_in_valid_i ? mk_code : 8'h00;
        stage_lost_d   = pic_data_in_valid_i && mk_cnt[1];
        marker_valid_d = stage_valid_q && stage_mk_q;
        marker_lost_d  = stage_valid_q && stage_lost_q;
        marker_code_d  = marker_valid_d ? stage_code_q : marker_code_q;
    end

    // Marker registers
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_mk_q     <= 1'b0;
            stage_code_q   <= '0;
            stage_lost_q   <= 1'b0;
            marker_valid_q <= 1'b0;
            marker_code_q  <= '0;
            marker_lost_q  <= 1'b0;
        end else begin
            stage_mk_q     <= stage_mk_d;
            stage_code_q   <= stage_code_d;
            stage_lost_q   <= stage_lost_d;
            marker_valid_q <= marker_valid_d;
            marker_code_q  <= marker_code_d;
            marker_lost_q  <= marker_lost_d;
        end
    end

    assign marker_valid_o = marker_valid_q;
    assign marker_code_o  = marker_code_q;
    assign marker_lost_o  = marker_lost_q;
`else
    assign marker_valid_o = 1'b0;
    assign marker_code_o  = 8'h00;
    assign marker_lost_o  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_unstuff.sv
// tb_decode_unstuff: scoreboard bench for decode_unstuff.
// Expected values follow the DECODE_UNSTUFF_MARKER_EN build setting.

module tb_decode_unstuff;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        int          cyc;
    } out_t;

    typedef struct packed {
        logic [7:0] code;
        logic       lost;
        int         cyc;
    } mk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic [2:0]  dout_bytes;
    logic        mk_valid;
    logic [7:0]  mk_code;
    logic        mk_lost;
    logic        flush_done;

    out_t exp_out[$];
    out_t obs_out[$];
    mk_t  exp_mk[$];
    mk_t  obs_mk[$];
    int   obs_done = 0;
    int   done_cyc = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    decode_unstuff #(.PIC_PIX_IN_WIDTH(32)) dut (
        .clk_x8_i             (clk),
        .rst_n_i              (rst_n),
        .pic_data_in_i        (din),
        .pic_data_in_valid_i  (din_valid),
        .flush_i              (flush),
        .pic_data_out_o       (dout),
        .pic_data_out_valid_o (dout_valid),
        .pic_data_out_bytes_o (dout_bytes),
        .marker_valid_o       (mk_valid),
        .marker_code_o        (mk_code),
        .marker_lost_o        (mk_lost),
        .flush_done_o         (flush_done)
    );

    // Free-running clock and edge counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every DUT output event away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) obs_out.push_back({dout, dout_bytes, cyc});
            if (mk_valid) obs_mk.push_back({mk_code, mk_lost, cyc});
            if (flush_done) begin
                obs_done = obs_done + 1;
                done_cyc = cyc;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic send(input logic [31:0] w, input logic v, input logic f);
        din       = w;
        din_valid = v;
        flush     = f;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({dout_valid, dout_bytes, dout} !== 36'h0) begin
            failures++;
            $display("[TB] FAIL reset_out got=%b/%0d/%h exp=0/0/0", dout_valid, dout_bytes, dout);
        end
        checks++;
        if ({mk_valid, mk_lost, mk_code} !== 10'h0) begin
            failures++;
            $display("[TB] FAIL reset_marker got=%b/%b/%h exp=0/0/00", mk_valid, mk_lost, mk_code);
        end
        checks++;
        if (flush_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flush_done got=%b exp=0", flush_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stuffing();
        out_t e, o;
        exp_out.delete(); obs_out.delete(); exp_mk.delete(); obs_mk.delete(); obs_done = 0;
        send(32'h00FF1234, 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b0);
        send(32'h0, 1'b0, 1'b0);
        send(32'h88776655, 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b1);
        exp_out.push_back({32'h55FF1234, 3'd4, 32'd0});
        exp_out.push_back({32'h00887766, 3'd3, 32'd0});
        repeat (4) send(32'h0, 1'b0, 1'b0);
        send(32'hFF332211, 1'b1, 1'b0);
        send(32'h44330000, 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b1);
        exp_out.push_back({32'hFF332211, 3'd4, 32'd0});
        exp_out.push_back({32'h00443300, 3'd3, 32'd0});
        repeat (4) send(32'h0, 1'b0, 1'b0);
        checks++;
        if (obs_out.size() != exp_out.size()) begin
            failures++;
            $display("[TB] FAIL stuffing word_count got=%0d exp=%0d", obs_out.size(), exp_out.size());
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            e = exp_out.pop_front();
            o = obs_out.pop_front();
            checks++;
            if (o.data !== e.data || o.bytes !== e.bytes) begin
                failures++;
                $display("[TB] FAIL stuffing word got=%h/%0d exp=%h/%0d", o.data, o.bytes, e.data, e.bytes);
            end
        end
        checks++;
        if (obs_mk.size() != 0) begin
            failures++;
            $display("[TB] FAIL stuffing marker_count got=%0d exp=0", obs_mk.size());
        end
        checks++;
        if (obs_done != 2) begin
            failures++;
            $display("[TB] FAIL stuffing flush_done_count got=%0d exp=2", obs_done);
        end
    endtask

    task automatic test_marker();
        out_t e, o;
        mk_t  em, om;
        int   c0, c1, c2;
        exp_out.delete(); obs_out.delete(); exp_mk.delete(); obs_mk.delete(); obs_done = 0;
        send(32'h66D9FF55, 1'b1, 1'b0);
        c0 = cyc;
        send(32'h0, 1'b0, 1'b1);
        repeat (4) send(32'h0, 1'b0, 1'b0);
        checks++;
        if (done_cyc != c0 + 2) begin
            failures++;
            $display("[TB] FAIL marker flush_done_cycle got=%0d exp=%0d", done_cyc, c0 + 2);
        end
        send(32'hD0FFFF11, 1'b1, 1'b0);
        c1 = cyc;
        send(32'h0, 1'b0, 1'b1);
        repeat (4) send(32'h0, 1'b0, 1'b0);
        send(32'hD1FFD0FF, 1'b1, 1'b0);
        c2 = cyc;
        send(32'h0, 1'b0, 1'b1);
        repeat (4) send(32'h0, 1'b0, 1'b0);
`ifdef DECODE_UNSTUFF_MARKER_EN
        exp_mk.push_back({8'hD9, 1'b0, c0 + 1});
        exp_out.push_back({32'h00006655, 3'd2, c0 + 2});
        exp_mk.push_back({8'hD0, 1'b0, c1 + 1});
        exp_out.push_back({32'h00000011, 3'd1, c1 + 2});
        exp_mk.push_back({8'hD1, 1'b1, c2 + 1});
`else
        exp_out.push_back({32'h66D9FF55, 3'd4, c0 + 1});
        exp_out.push_back({32'hD0FFFF11, 3'd4, c1 + 1});
        exp_out.push_back({32'hD1FFD0FF, 3'd4, c2 + 1});
`endif
        checks++;
        if (obs_out.size() != exp_out.size()) begin
            failures++;
            $display("[TB] FAIL marker word_count got=%0d exp=%0d", obs_out.size(), exp_out.size());
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            e = exp_out.pop_front();
            o = obs_out.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL marker word got=%h/%0d@%0d exp=%h/%0d@%0d", o.data, o.bytes, o.cyc, e.data, e.bytes, e.cyc);
            end
        end
        checks++;
        if (obs_mk.size() != exp_mk.size()) begin
            failures++;
            $display("[TB] FAIL marker marker_count got=%0d exp=%0d", obs_mk.size(), exp_mk.size());
        end
        while (exp_mk.size() > 0 && obs_mk.size() > 0) begin
            em = exp_mk.pop_front();
            om = obs_mk.pop_front();
            checks++;
            if (om !== em) begin
                failures++;
                $display("[TB] FAIL marker code got=%h/lost%b@%0d exp=%h/lost%b@%0d", om.code, om.lost, om.cyc, em.code, em.lost, em.cyc);
            end
        end
        checks++;
        if (obs_done != 3) begin
            failures++;
            $display("[TB] FAIL marker flush_done_count got=%0d exp=3", obs_done);
        end
    endtask

    task automatic test_flush_ff();
        out_t e, o;
        exp_out.delete(); obs_out.delete(); exp_mk.delete(); obs_mk.delete(); obs_done = 0;
        send(32'hFF030201, 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b1);
        repeat (4) send(32'h0, 1'b0, 1'b0);
`ifdef DECODE_UNSTUFF_MARKER_EN
        exp_out.push_back({32'h00030201, 3'd3, 32'd0});
`else
        exp_out.push_back({32'hFF030201, 3'd4, 32'd0});
`endif
        send(32'h00000000, 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b1);
        exp_out.push_back({32'h00000000, 3'd4, 32'd0});
        repeat (4) send(32'h0, 1'b0, 1'b0);
        checks++;
        if (obs_out.size() != exp_out.size()) begin
            failures++;
            $display("[TB] FAIL flush_ff word_count got=%0d exp=%0d", obs_out.size(), exp_out.size());
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            e = exp_out.pop_front();
            o = obs_out.pop_front();
            checks++;
            if (o.data !== e.data || o.bytes !== e.bytes) begin
                failures++;
                $display("[TB] FAIL flush_ff word got=%h/%0d exp=%h/%0d", o.data, o.bytes, e.data, e.bytes);
            end
        end
        checks++;
        if (obs_done != 2) begin
            failures++;
            $display("[TB] FAIL flush_ff flush_done_count got=%0d exp=2", obs_done);
        end
    endtask

    task automatic test_midstream_reset();
        out_t e, o;
        send(32'h44332211, 1'b1, 1'b0);
        send(32'hFF776655, 1'b1, 1'b0);
        send(32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({dout_valid, dout_bytes, dout, mk_valid, flush_done} !== 38'h0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got=%b/%0d/%h/%b/%b exp=all zero", dout_valid, dout_bytes, dout, mk_valid, flush_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_out.delete(); obs_out.delete(); exp_mk.delete(); obs_mk.delete(); obs_done = 0;
        send(32'h11223300, 1'b1, 1'b1);
        exp_out.push_back({32'h11223300, 3'd4, 32'd0});
        repeat (4) send(32'h0, 1'b0, 1'b0);
        checks++;
        if (obs_out.size() != exp_out.size()) begin
            failures++;
            $display("[TB] FAIL midreset word_count got=%0d exp=%0d", obs_out.size(), exp_out.size());
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            e = exp_out.pop_front();
            o = obs_out.pop_front();
            checks++;
            if (o.data !== e.data || o.bytes !== e.bytes) begin
                failures++;
                $display("[TB] FAIL midreset word got=%h/%0d exp=%h/%0d", o.data, o.bytes, e.data, e.bytes);
            end
        end
        checks++;
        if (obs_done != 1) begin
            failures++;
            $display("[TB] FAIL midreset flush_done_count got=%0d exp=1", obs_done);
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        logic [7:0]  payload[$];
        logic [7:0]  stream[$];
        logic [7:0]  b;
        logic [31:0] w;
        int          n, nb, nw;
        exp_out.delete(); obs_out.delete(); exp_mk.delete(); obs_mk.delete(); obs_done = 0;
        for (int r = 0; r < 4; r++) begin
            payload.delete();
            stream.delete();
            n = $urandom_range(9, 30);
            for (int i = 0; i < n; i++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                payload.push_back(b);
                stream.push_back(b);
                if (b == 8'hFF) stream.push_back(8'h00);
            end
            while ((stream.size() % 4) != 0) begin
                payload.push_back(8'h5A);
                stream.push_back(8'h5A);
            end
            for (int k = 0; k < payload.size(); k += 4) begin
                w  = '0;
                nb = 0;
                for (int j = 0; j < 4; j++) begin
                    if (k + j < payload.size()) begin
                        w[j*8 +: 8] = payload[k + j];
                        nb++;
                    end
                end
                exp_out.push_back({w, 3'(nb), 32'd0});
            end
            nw = stream.size() / 4;
            for (int k = 0; k < nw; k++) begin
                send({stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]}, 1'b1, (k == nw - 1));
            end
            repeat (5) send(32'h0, 1'b0, 1'b0);
        end
        checks++;
        if (obs_out.size() != exp_out.size()) begin
            failures++;
            $display("[TB] FAIL back_to_back word_count got=%0d exp=%0d", obs_out.size(), exp_out.size());
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            e = exp_out.pop_front();
            o = obs_out.pop_front();
            checks++;
            if (o.data !== e.data || o.bytes !== e.bytes) begin
                failures++;
                $display("[TB] FAIL back_to_back word got=%h/%0d exp=%h/%0d", o.data, o.bytes, e.data, e.bytes);
            end
        end
        checks++;
        if (obs_mk.size() != 0) begin
            failures++;
            $display("[TB] FAIL back_to_back marker_count got=%0d exp=0", obs_mk.size());
        end
        checks++;
        if (obs_done != 4) begin
            failures++;
            $display("[TB] FAIL back_to_back flush_done_count got=%0d exp=4", obs_done);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_stuffing();
        test_marker();
        test_flush_ff();
        test_midstream_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_unstuff.md
# decode_unstuff

JPEG entropy-stream byte unstuffer for the decode path: the inverse of the encoder's 0xFF→0xFF00 stuffing stage. Accepts 32-bit words of scan data, removes stuffed 0x00 bytes, strips fill bytes, extracts markers (0xFF followed by a non-zero code), and repacks surviving bytes into dense 32-bit output words. Sits between the bitstream input FIFO and the Huffman decoder.

## Interface
- PIC_PIX_IN_WIDTH, 32, word width in bits; only 32 is supported (4 bytes/word).
- clk_x8_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- pic_data_in_i  in  32  input word; byte 0 = [7:0] is earliest in stream, byte 3 = [31:24] is latest.
- pic_data_in_valid_i  in  1  word valid; sampled every rising edge; no backpressure.
- flush_i  in  1  one-cycle pulse: emit residual bytes after the last accepted word.
- pic_data_out_o  out  32  repacked word, byte 0 earliest; unused high bytes 0x00.
- pic_data_out_valid_o  out  1  one-cycle pulse per output word.
- pic_data_out_bytes_o  out  3  valid byte count of pic_data_out_o: 4, or 1–3 on flush.
- marker_valid_o  out  1  one-cycle pulse: marker extracted.
- marker_code_o  out  8  code byte of the last marker in the word.
- marker_lost_o  out  1  pulse with marker_valid_o when a word held two markers (first dropped).
- flush_done_o  out  1  one-cycle pulse when flush completes.

## Operation
- Stage 1 (scan): bytes 0..3 processed in order with carried flag pend_ff (an 0xFF withheld, not yet emitted).
  - pend_ff=0, byte≠0xFF: keep byte.
  - pend_ff=0, byte=0xFF: set pend_ff, emit nothing.
  - pend_ff=1, byte=0x00: keep 0xFF, drop 0x00, clear pend_ff.
  - pend_ff=1, byte=0xFF: fill byte; drop one 0xFF; pend_ff stays 1.
  - pend_ff=1, other byte: marker; drop both; record code; clear pend_ff.
  - pend_ff carries across words. Kept bytes (0–4) are compacted low-first into a stage register with their count and the marker info.
- Stage 2 (assemble): residual buffer acc (0–3 bytes) + stage bytes = total (≤7). If total ≥4, output the lowest 4 and keep the rest in acc; otherwise acc = total. Invariant: acc ≤3 after every edge.
- Markers are reported at the edge where their word's stage data is assembled. Data ahead of a marker within the word is emitted at or before that edge, and data behind it at or after.
- Flush: flush_i sets flush_pend. The flush executes at the first edge with flush_pend=1 and the stage register empty. If acc>0, emit acc zero-padded with pic_data_out_bytes_o=acc. Then clear acc and pend_ff (a withheld 0xFF is discarded), pulse flush_done_o, and clear flush_pend. pic_data_in_valid_i must be low from the cycle after flush_i until flush_done_o. flush_i together with valid applies after that word.

## Timing
- All outputs reset to 0; pend_ff, acc count, stage valid and flush_pend reset to 0. Reset mid-stream discards all buffered bytes and the withheld 0xFF.
- Latency: word sampled at edge E0 → stage register at E0 → output/marker registered at E1 (visible in the cycle after E1).
- Sustained throughput: one input word per cycle. The output never overflows because ≤4 bytes enter and ≥4 leave whenever total ≥4.
- Flush with an empty pipeline: flush_done_o and any residual word appear one edge after flush_i is sampled.
- Idle input cycles hold acc unchanged; the output valid signals are low.

## Configuration
- DECODE_UNSTUFF_MARKER_EN defined: marker extraction and fill-byte removal as above.
- Undefined: only the 0xFF00→0xFF rule applies. 0xFF followed by a non-zero byte passes both bytes through as data (including 0xFF 0xFF). marker_valid_o, marker_code_o and marker_lost_o are tied 0.

## Test plan
- Words 0x00FF1234 then 0x88776655 → one output 0x55FF1234 (bytes=4); acc holds 66,77,88.
- Word 0xFF332211, then 0x44330000 → output 0xFF332211; acc holds 00,33,44 (cross-word stuffing).
- Word 0x66D9FF55, then flush_i → marker_valid_o with code 0xD9 one edge after; flush outputs 0x00006655 (bytes=2); then flush_done_o.
- Word 0xD0FFFF11 → marker code 0xD0; acc holds only 0x11 (fill byte dropped).
- Word 0xD1FFD0FF → marker_valid_o with code 0xD1; marker_lost_o=1.
- 0xFF as the last byte, then flush_i → withheld 0xFF discarded; reset during a stream → all outputs 0 and the next word decodes from an empty buffer.
